warn_monitor: RTL

WARN_MONITOR -- requirements
Module: warn_monitor

---
 rtl/warn_monitor.sv | 133 +++++++++++++
 1 files changed

// File: rtl/warn_monitor.sv
// Per-channel warning stretcher: synchronised event inputs, edge/level triggers, hold counters, sticky flags.
// Define WARN_MONITOR_EVTCNT_EN to build the saturating per-channel event counters; otherwise evt_cnt_o is tied to 0.
module warn_monitor #(
    parameter int NUM_CH      = 4,
    parameter int HOLD_W      = 24,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk27,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NUM_CH-1:0]       event_i,
    input  logic [NUM_CH-1:0]       level_mode,
    input  logic [HOLD_W-1:0]       hold_len,
    input  logic                    clear_i,
    output logic [NUM_CH-1:0]       warn_o,
    output logic                    warn_any_o,
    output logic [NUM_CH-1:0]       sticky_o,
    output logic [NUM_CH*CNT_W-1:0] evt_cnt_o
);

    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_p0;
    logic [NUM_CH-1:0]                  sync;
    logic [NUM_CH-1:0]                  prev_p1;
    logic [NUM_CH-1:0]                  rise;
    logic [NUM_CH-1:0]                  trig;
    logic [NUM_CH-1:0]                  trig_p2;
    logic [NUM_CH-1:0]                  rise_p2;
    logic [NUM_CH-1:0]                  count_evt;
    logic [NUM_CH-1:0][HOLD_W-1:0]      hold_p3;
    logic [NUM_CH-1:0]                  sticky_p3;

    // Stage 0: synchronizer chain, free-running regardless of enable
    always_ff @(posedge clk27 or posedge reset) begin
        if (reset) begin
            sync_p0 <= '0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], event_i};
        end
    end

    assign sync = sync_p0[SYNC_STAGES-1];

    // Stage 1: edge-detect history of the synchronised input
    always_ff @(posedge clk27 or posedge reset) begin
        if (reset) begin
            prev_p1 <= '0;
        end else begin
            prev_p1 <= sync;
        end
    end

    assign rise = sync & ~prev_p1;
    assign trig = (level_mode & sync) | (~level_mode & rise);

    // Stage 2: registered trigger and rising-edge strobes
    always_ff @(posedge clk27 or posedge reset) begin
        if (reset) begin
            trig_p2 <= '0;
            rise_p2 <= '0;
        end else begin
            trig_p2 <= trig;
            rise_p2 <= rise;
        end
    end

    assign count_evt = rise_p2 & {NUM_CH{enable}};

    // Stage 3: hold counters, frozen entirely while enable is low
    always_ff @(posedge clk27 or posedge reset) begin
        if (reset) begin
            hold_p3 <= '0;
        end else if (enable) begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (trig_p2[n]) begin
                    hold_p3[n] <= hold_len;
                end else if (hold_p3[n] != '0) begin
                    hold_p3[n] <= hold_p3[n] - HOLD_ONE;
                end
            end
        end
    end

    // A counted edge in the same cycle as clear_i still sets its flag
    always_ff @(posedge clk27 or posedge reset) begin
        if (reset) begin
            sticky_p3 <= '0;
        end else begin
            sticky_p3 <= (clear_i ? '0 : sticky_p3) | count_evt;
        end
    end

`ifdef WARN_MONITOR_EVTCNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NUM_CH-1:0][CNT_W-1:0] cnt_p3;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    always_ff @(posedge clk27 or posedge reset) begin
        if (reset) begin
            cnt_p3 <= '0;
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (count_evt[n]) begin
                    cnt_p3[n] <= clear_i ? CNT_ONE : sat_inc(cnt_p3[n]);
                end else if (clear_i) begin
                    cnt_p3[n] <= '0;
                end
            end
        end
    end

    assign evt_cnt_o = cnt_p3;
`else
    assign evt_cnt_o = '0;
`endif

    always_comb begin
        warn_o = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            warn_o[n] = (hold_p3[n] != '0);
        end
    end

    assign warn_any_o = |warn_o;
    assign sticky_o   = sticky_p3;

endmodule
